player_input_conditioner: RTL and testbench

- Conditions the raw board buttons (left, right, missile) before they reach the ship-drawing stage.
- Directly upstream of the ship stage. Replaces the bare 2-cycle delay on left/right; the missile button also passes through this block instead of going in raw.
- Per button: synchronises, debounces, and resolves left/right conflicts.
- Turns the missile button into rate-limited single-cycle fire pulses, with optional autofire.

---
 rtl/player_input_conditioner.sv | 135 +++++++++++++
 tb/tb_player_input_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_conditioner.sv
// Button front end for the ship stage: synchronises and debounces left/right/fire,
// resolves left/right conflicts, and turns the fire button into rate-limited pulses.
module player_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int DB_W            = 20,
    parameter int COOLDOWN_CYCLES = 16250000,
    parameter int CD_W            = 24,
    parameter bit AUTOFIRE        = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic left_in,
    input  logic right_in,
    input  logic fire_in,
    output logic left_out,
    output logic right_out,
    output logic fire_pulse,
    output logic fire_ready
);

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_F = 2;
    localparam int NUM_BTN = 3;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic {
        S_READY = 1'b0,
        S_COOL  = 1'b1
    } fireState_t;

    logic [NUM_BTN-1:0]           w_raw;
    logic [NUM_BTN-1:0]           r_meta;
    logic [NUM_BTN-1:0]           r_sync;
    logic [NUM_BTN-1:0]           r_stable;
    logic [NUM_BTN-1:0][DB_W-1:0] r_dbCnt;

    logic                         r_leftOut;
    logic                         r_rightOut;

    fireState_t                   r_state;
    logic [CD_W-1:0]              r_cdCnt;
    logic                         r_stFirePrev;
    logic                         r_firePulse;
    logic                         r_fireReady;
    logic                         w_fireEvent;

    assign w_raw = {fire_in, right_in, left_in};

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // A new level is accepted only after it has held for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            r_dbCnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_leftOut  <= 1'b0;
            r_rightOut <= 1'b0;
        end else begin
            r_leftOut  <= r_stable[BTN_L] & ~r_stable[BTN_R];
            r_rightOut <= r_stable[BTN_R] & ~r_stable[BTN_L];
        end
    end

    assign w_fireEvent = AUTOFIRE ? r_stable[BTN_F]
                                  : (r_stable[BTN_F] & ~r_stFirePrev);

    // Presses seen while cooling down are simply lost; the edge history keeps updating.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_READY;
            r_cdCnt      <= '0;
            r_stFirePrev <= 1'b0;
            r_firePulse  <= 1'b0;
            r_fireReady  <= 1'b1;
        end else begin
            r_stFirePrev <= r_stable[BTN_F];
            r_firePulse  <= 1'b0;
            case (r_state)
                S_READY: begin
                    if (w_fireEvent) begin
                        r_firePulse <= 1'b1;
                        r_cdCnt     <= CD_LOAD;
                        r_state     <= S_COOL;
                        r_fireReady <= 1'b0;
                    end
                end
                S_COOL: begin
                    if (r_cdCnt == '0) begin
                        r_state     <= S_READY;
                        r_fireReady <= 1'b1;
                    end else begin
                        r_cdCnt <= r_cdCnt - CD_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_READY;
                    r_fireReady <= 1'b1;
                end
            endcase
        end
    end

    assign left_out   = r_leftOut;
    assign right_out  = r_rightOut;
    assign fire_pulse = r_firePulse;
    assign fire_ready = r_fireReady;

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: one instance without and one with autofire,
// sharing clock, reset and direction buttons but with separate fire buttons.
module tb_player_input_conditioner;

    localparam int DEB  = 8;
    localparam int COOL = 20;
    localparam int LAT  = DEB + 3;

    logic pclk    = 1'b0;
    logic rst     = 1'b0;
    logic leftIn  = 1'b1;
    logic rightIn = 1'b1;
    logic fireIn0 = 1'b1;
    logic fireIn1 = 1'b0;

    logic leftOut0, rightOut0, firePulse0, fireReady0;
    logic leftOut1, rightOut1, firePulse1, fireReady1;

    int cyc        = 0;
    int passCount  = 0;
    int checkCount = 0;

    int expPulse0[$];
    int expPulse1[$];

    typedef struct {
        logic l;
        logic r;
        int   hold;
        logic expL;
        logic expR;
    } vec_t;

    typedef struct {
        logic l;
        logic r;
    } exp_t;

    vec_t vecs[10];
    exp_t sbq[$];

    player_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .DB_W(4), .COOLDOWN_CYCLES(COOL), .CD_W(5), .AUTOFIRE(1'b0)
    ) dut0 (
        .pclk(pclk), .rst(rst), .left_in(leftIn), .right_in(rightIn), .fire_in(fireIn0),
        .left_out(leftOut0), .right_out(rightOut0), .fire_pulse(firePulse0), .fire_ready(fireReady0)
    );

    player_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .DB_W(4), .COOLDOWN_CYCLES(COOL), .CD_W(5), .AUTOFIRE(1'b1)
    ) dut1 (
        .pclk(pclk), .rst(rst), .left_in(leftIn), .right_in(rightIn), .fire_in(fireIn1),
        .left_out(leftOut1), .right_out(rightOut1), .fire_pulse(firePulse1), .fire_ready(fireReady1)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic l, input logic r);
        leftIn  = l;
        rightIn = r;
    endtask

    function automatic logic getSig(input int sel);
        case (sel)
            0:       return leftOut0;
            1:       return rightOut0;
            2:       return fireReady0;
            default: return 1'b0;
        endcase
    endfunction

    // Waits (bounded) for a level and checks how many cycles after startCyc it appeared.
    task automatic waitLevel(input string name, input int sel, input logic level,
                             input int startCyc, input int expDelta);
        int found;
        found = -1;
        for (int t = 0; t < 60; t++) begin
            @(negedge pclk);
            if (getSig(sel) == level) begin
                found = cyc - startCyc;
                break;
            end
        end
        checkOutput(name, found, expDelta);
    endtask

    initial begin
        int k;
        int bad;

        vecs[0] = '{1'b0, 1'b0, 15, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 10, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0,  1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 15, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 15, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 15, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 15, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0,  5, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 15, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 15, 1'b0, 1'b0};

        fork
            forever begin
                @(negedge pclk);
                if (firePulse0) begin
                    if (expPulse0.size() == 0) checkOutput("dut0 unexpected fire_pulse cycle", cyc, -1);
                    else checkOutput("dut0 fire_pulse cycle", cyc, expPulse0.pop_front());
                end
                if (firePulse1) begin
                    if (expPulse1.size() == 0) checkOutput("dut1 unexpected fire_pulse cycle", cyc, -1);
                    else checkOutput("dut1 fire_pulse cycle", cyc, expPulse1.pop_front());
                end
            end
        join_none

        $display("[TB] reset with all buttons held");
        repeat (3) @(negedge pclk);
        checkOutput("reset left_out", leftOut0, 0);
        checkOutput("reset right_out", rightOut0, 0);
        checkOutput("reset fire_pulse", firePulse0, 0);
        checkOutput("reset fire_ready dut0", fireReady0, 1);
        checkOutput("reset fire_ready dut1", fireReady1, 1);
        rst = 1'b1;
        k = cyc;
        expPulse0.push_back(k + LAT);
        bad = 0;
        repeat (40) begin
            @(negedge pclk);
            if (leftOut0 | rightOut0 | leftOut1 | rightOut1) bad++;
        end
        checkOutput("direction cycles active with both held", bad, 0);
        checkOutput("dut0 pulses missing after release", expPulse0.size(), 0);
        applyStimulus(1'b0, 1'b0);
        fireIn0 = 1'b0;
        repeat (20) @(negedge pclk);

        $display("[TB] debounce glitch on left");
        leftIn = 1'b1;
        repeat (5) @(negedge pclk);
        leftIn = 1'b0;
        @(negedge pclk);
        leftIn = 1'b1;
        waitLevel("left_out rise after glitch", 0, 1'b1, cyc, LAT);
        checkOutput("right_out during left press", rightOut0, 0);

        $display("[TB] left/right conflict");
        rightIn = 1'b1;
        waitLevel("left_out fall on conflict", 0, 1'b0, cyc, LAT);
        checkOutput("right_out while both held", rightOut0, 0);
        leftIn = 1'b0;
        waitLevel("right_out rise after left release", 1, 1'b1, cyc, LAT);
        rightIn = 1'b0;
        repeat (20) @(negedge pclk);

        $display("[TB] direction vector table");
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            applyStimulus(vecs[i].l, vecs[i].r);
            sbq.push_back('{vecs[i].expL, vecs[i].expR});
            repeat (vecs[i].hold) @(negedge pclk);
            e = sbq.pop_front();
            checkOutput($sformatf("vec%0d dut0 left_out", i), leftOut0, e.l);
            checkOutput($sformatf("vec%0d dut0 right_out", i), rightOut0, e.r);
            checkOutput($sformatf("vec%0d dut1 left_out", i), leftOut1, e.l);
            checkOutput($sformatf("vec%0d dut1 right_out", i), rightOut1, e.r);
        end

        $display("[TB] press during cooldown is dropped");
        k = cyc;
        fireIn0 = 1'b1;
        expPulse0.push_back(k + LAT);
        for (int t = 1; t <= 75; t++) begin
            @(negedge pclk);
            case (t)
                8:  fireIn0 = 1'b0;
                10: checkOutput("fire_ready before first pulse", fireReady0, 1);
                11: checkOutput("fire_ready entering cooldown", fireReady0, 0);
                18: fireIn0 = 1'b1;
                29: checkOutput("fire_ready when dropped press lands", fireReady0, 0);
                30: checkOutput("fire_ready last cooldown cycle", fireReady0, 0);
                31: checkOutput("fire_ready after cooldown", fireReady0, 1);
                35: fireIn0 = 1'b0;
                50: begin
                    fireIn0 = 1'b1;
                    expPulse0.push_back(cyc + LAT);
                end
                65: fireIn0 = 1'b0;
                default: ;
            endcase
        end
        repeat (20) @(negedge pclk);
        checkOutput("dut0 pulses missing after cooldown test", expPulse0.size(), 0);

        $display("[TB] autofire hold");
        k = cyc;
        fireIn1 = 1'b1;
        for (int n = 0; n < 5; n++) expPulse1.push_back(k + LAT + n * (COOL + 1));
        repeat (100) @(negedge pclk);
        fireIn1 = 1'b0;
        repeat (40) @(negedge pclk);
        checkOutput("dut1 pulses missing after autofire", expPulse1.size(), 0);

        $display("[TB] reset during cooldown");
        k = cyc;
        fireIn0 = 1'b1;
        expPulse0.push_back(k + LAT);
        repeat (15) @(negedge pclk);
        checkOutput("fire_ready in cooldown before reset", fireReady0, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("fire_ready right after async reset", fireReady0, 1);
        checkOutput("fire_pulse right after async reset", firePulse0, 0);
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        expPulse0.push_back(cyc + LAT);
        repeat (40) @(negedge pclk);
        fireIn0 = 1'b0;
        repeat (20) @(negedge pclk);
        checkOutput("dut0 pulses missing after mid reset", expPulse0.size(), 0);
        checkOutput("fire_ready idle at end", fireReady0, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
